// File: rtl/dpd_coef_lms.sv
// LMS coefficient adaptation engine for a 3-tap-memory, 5th-order DPD core.
// For each accepted sample it runs one time-shared complex MAC pass over the 15 basis terms:
//   c[k] += mu * conj(y[k]) * e,  mu = 2^-mu_shift
// The new coefficient set is published atomically when the pass ends.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   en_i                    adaptation enable, only looked at while idle
//   clr_i                   synchronous clear: abort the pass and reload the init coefficients
//   smp_vld_i               yy / err are valid and aligned this cycle
//   err_i_i, err_q_i        complex error sample, s20 Q1.19
//   mu_shift_i              step-size exponent, captured with the sample
//   yy_i_i, yy_q_i          15 basis terms, word k at [20k+19:20k], s20 Q1.19
//   coeff_i_o, coeff_q_o    15 coefficients, same packing, s20 Q1.19
//   busy_o                  pass in progress (MAC or COMMIT)
//   done_o                  1-cycle pulse on the cycle coeff updates
//   n_upd_o                 completed passes (wraps)
//   n_drop_o                ignored strobes (saturates)
module dpd_coef_lms #(
  parameter int unsigned        InitTap = 2,
  parameter logic signed [19:0] InitRe  = 20'sh40000
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         smp_vld_i,
  input  logic [19:0]  err_i_i,
  input  logic [19:0]  err_q_i,
  input  logic [3:0]   mu_shift_i,
  input  logic [299:0] yy_i_i,
  input  logic [299:0] yy_q_i,
  output logic [299:0] coeff_i_o,
  output logic [299:0] coeff_q_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [15:0]  n_upd_o,
  output logic [15:0]  n_drop_o
);

  localparam int unsigned AccW = 32;

  typedef enum logic [1:0] {StIdle, StMac, StCommit} state_e;
  state_e state_q, state_d;

  logic signed [19:0]     snap_yi_q [15];
  logic signed [19:0]     snap_yq_q [15];
  logic signed [19:0]     snap_ei_q, snap_eq_q;
  logic [3:0]             snap_mu_q;
  logic [3:0]             k_q;
  logic                   p_vld_q;
  logic [3:0]             p_idx_q;
  logic signed [40:0]     pr_q, pi_q;
  logic signed [AccW-1:0] acc_re_q [15];
  logic signed [AccW-1:0] acc_im_q [15];
  logic signed [19:0]     coef_re_q [15];
  logic signed [19:0]     coef_im_q [15];
  logic                   done_q;
  logic [15:0]            n_upd_q, n_drop_q;

  logic                   capture, drop, commit;
  logic [3:0]             k_sel;
  logic signed [19:0]     cur_yi, cur_yq;
  logic signed [39:0]     m_ii, m_qq, m_iq, m_qi;
  logic signed [40:0]     prod_re, prod_im, d_re, d_im;
  logic [4:0]             sh;
  logic signed [41:0]     sum_re, sum_im;

  function automatic logic signed [AccW-1:0] sat32(input logic signed [41:0] v);
    if (v[41:31] == {11{v[41]}}) return v[31:0];
    return v[41] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
  endfunction

  always_comb begin
    capture = (state_q == StIdle) && smp_vld_i && en_i && !clr_i;
    drop    = smp_vld_i && !clr_i && ((state_q != StIdle) || !en_i);
    commit  = (state_q == StCommit) && !clr_i;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (smp_vld_i && en_i) state_d = StMac;
      // Last accumulator write happens on this edge; publish on the next one.
      StMac:    if (p_vld_q && p_idx_q == 4'd14) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (clr_i) state_d = StIdle;
  end

  // Stage 1: conj(y[k]) * e for the current index.
  // Stage 2: scale by mu (floor shift) and saturate into acc.
  always_comb begin
    k_sel   = (k_q < 4'd15) ? k_q : 4'd0;
    cur_yi  = snap_yi_q[k_sel];
    cur_yq  = snap_yq_q[k_sel];
    m_ii    = 40'(cur_yi) * 40'(snap_ei_q);
    m_qq    = 40'(cur_yq) * 40'(snap_eq_q);
    m_iq    = 40'(cur_yi) * 40'(snap_eq_q);
    m_qi    = 40'(cur_yq) * 40'(snap_ei_q);
    prod_re = 41'(m_ii) + 41'(m_qq);
    prod_im = 41'(m_iq) - 41'(m_qi);
    sh      = 5'd7 + {1'b0, snap_mu_q};
    d_re    = pr_q >>> sh;
    d_im    = pi_q >>> sh;
    sum_re  = 42'(acc_re_q[p_idx_q]) + 42'(d_re);
    sum_im  = 42'(acc_im_q[p_idx_q]) + 42'(d_im);
  end

  always_ff @(posedge clk_i) begin
    if (capture && !reset_i) begin
      for (int k = 0; k < 15; k++) begin
        snap_yi_q[k] <= yy_i_i[20*k +: 20];
        snap_yq_q[k] <= yy_q_i[20*k +: 20];
      end
      snap_ei_q <= err_i_i;
      snap_eq_q <= err_q_i;
      snap_mu_q <= mu_shift_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      k_q      <= 4'd0;
      p_vld_q  <= 1'b0;
      p_idx_q  <= 4'd0;
      pr_q     <= '0;
      pi_q     <= '0;
      done_q   <= 1'b0;
      n_upd_q  <= 16'd0;
      n_drop_q <= 16'd0;
      for (int k = 0; k < 15; k++) begin
        acc_re_q[k]  <= (k == InitTap) ? {InitRe, 12'h000} : '0;
        acc_im_q[k]  <= '0;
        coef_re_q[k] <= (k == InitTap) ? InitRe : '0;
        coef_im_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= commit;
      if (commit) n_upd_q <= n_upd_q + 16'd1;
      if (drop && n_drop_q != 16'hFFFF) n_drop_q <= n_drop_q + 16'd1;
      if (clr_i) begin
        k_q     <= 4'd0;
        p_vld_q <= 1'b0;
        for (int k = 0; k < 15; k++) begin
          acc_re_q[k]  <= (k == InitTap) ? {InitRe, 12'h000} : '0;
          acc_im_q[k]  <= '0;
          coef_re_q[k] <= (k == InitTap) ? InitRe : '0;
          coef_im_q[k] <= '0;
        end
      end else begin
        if (capture) k_q <= 4'd0;
        if (state_q == StMac && k_q != 4'd15) begin
          pr_q    <= prod_re;
          pi_q    <= prod_im;
          p_idx_q <= k_q;
          p_vld_q <= 1'b1;
          k_q     <= k_q + 4'd1;
        end else begin
          p_vld_q <= 1'b0;
        end
        if (p_vld_q) begin
          acc_re_q[p_idx_q] <= sat32(sum_re);
          acc_im_q[p_idx_q] <= sat32(sum_im);
        end
        if (commit) begin
          for (int k = 0; k < 15; k++) begin
            coef_re_q[k] <= acc_re_q[k][31:12];
            coef_im_q[k] <= acc_im_q[k][31:12];
          end
        end
      end
    end
  end

  always_comb begin
    coeff_i_o = '0;
    coeff_q_o = '0;
    for (int k = 0; k < 15; k++) begin
      coeff_i_o[20*k +: 20] = coef_re_q[k];
      coeff_q_o[20*k +: 20] = coef_im_q[k];
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = done_q;
  assign n_upd_o  = n_upd_q;
  assign n_drop_o = n_drop_q;

endmodule

// File: tb/tb_dpd_coef_lms.sv
// Self-checking bench for dpd_coef_lms: a sample-level reference model publishes the expected
// coefficient set 17 clocks after each capture, compared every cycle, plus literal checks.
module tb_dpd_coef_lms;

  logic         clk = 1'b0;
  logic         reset, en, clr, smp_vld;
  logic [19:0]  err_i, err_q;
  logic [3:0]   mu_shift;
  logic [299:0] yy_i, yy_q, coeff_i, coeff_q;
  logic         busy, done;
  logic [15:0]  n_upd, n_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpd_coef_lms dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .en_i       (en),
    .clr_i      (clr),
    .smp_vld_i  (smp_vld),
    .err_i_i    (err_i),
    .err_q_i    (err_q),
    .mu_shift_i (mu_shift),
    .yy_i_i     (yy_i),
    .yy_q_i     (yy_q),
    .coeff_i_o  (coeff_i),
    .coeff_q_o  (coeff_q),
    .busy_o     (busy),
    .done_o     (done),
    .n_upd_o    (n_upd),
    .n_drop_o   (n_drop)
  );

  task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint       m_re [15];
  longint       m_im [15];
  longint       p_re [15];
  longint       p_im [15];
  int           m_cnt;
  logic [299:0] exp_ci, exp_cq;
  logic         exp_done, exp_busy;
  logic [15:0]  exp_upd, exp_drop;

  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  task automatic m_publish();
    longint t;
    for (int k = 0; k < 15; k++) begin
      t = m_re[k] >>> 12;
      exp_ci[20*k +: 20] = t[19:0];
      t = m_im[k] >>> 12;
      exp_cq[20*k +: 20] = t[19:0];
    end
  endtask

  task automatic m_init();
    for (int k = 0; k < 15; k++) begin
      m_re[k] = (k == 2) ? (longint'(262144) * 4096) : 0;
      m_im[k] = 0;
    end
    m_publish();
  endtask

  // Whole pass evaluated at capture time; becomes visible only at commit.
  task automatic m_capture();
    longint yi, yq, ei, eq, pr, pim;
    ei = longint'($signed(err_i));
    eq = longint'($signed(err_q));
    for (int k = 0; k < 15; k++) begin
      yi = longint'($signed(yy_i[20*k +: 20]));
      yq = longint'($signed(yy_q[20*k +: 20]));
      pr  = yi * ei + yq * eq;
      pim = yi * eq - yq * ei;
      p_re[k] = clamp32(m_re[k] + (pr >>> (7 + int'(mu_shift))));
      p_im[k] = clamp32(m_im[k] + (pim >>> (7 + int'(mu_shift))));
    end
  endtask

  always @(posedge clk) begin
    exp_done = 1'b0;
    if (reset) begin
      m_init();
      m_cnt = 0;
      exp_upd = 16'd0;
      exp_drop = 16'd0;
    end else if (clr) begin
      m_init();
      m_cnt = 0;
    end else if (m_cnt == 0) begin
      if (smp_vld && en) begin
        m_capture();
        m_cnt = 1;
      end else if (smp_vld && exp_drop != 16'hFFFF) begin
        exp_drop = exp_drop + 16'd1;
      end
    end else begin
      if (smp_vld && exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
      if (m_cnt == 17) begin
        for (int k = 0; k < 15; k++) begin
          m_re[k] = p_re[k];
          m_im[k] = p_im[k];
        end
        m_publish();
        exp_done = 1'b1;
        exp_upd = exp_upd + 16'd1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    exp_busy = (m_cnt != 0);
  end

  always @(posedge clk) begin
    #1;
    check("coeff_i", coeff_i, exp_ci);
    check("coeff_q", coeff_q, exp_cq);
    check("busy", busy, exp_busy);
    check("done", done, exp_done);
    check("n_upd", n_upd, exp_upd);
    check("n_drop", n_drop, exp_drop);
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse();
    smp_vld = 1'b1;
    @(negedge clk);
    smp_vld = 1'b0;
  endtask

  // Returns the edge offset from the capture edge at which done was seen, 0 if never.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int           lat, dcnt;
    logic [15:0]  upd0, drop0;
    logic [299:0] init_v, sat_v;
    init_v = '0;
    init_v[59:40] = 20'h40000;
    sat_v = {15{20'h7FFFF}};

    reset = 1'b1; en = 1'b1; clr = 1'b0; smp_vld = 1'b0;
    err_i = '0; err_q = '0; mu_shift = '0; yy_i = '0; yy_q = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_coeff_i", coeff_i, init_v);
    check("rst_coeff_q", coeff_q, 300'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_n_upd", n_upd, 16'd0);

    // y0=(0.5,0), e=(0.25,0)
    yy_i[19:0] = 20'h40000;
    err_i = 20'h20000;
    pulse();
    wait_done(lat);
    check("latency", lat, 17);
    check("t1_ci0", coeff_i[19:0], 20'h10000);
    check("t1_cq0", coeff_q[19:0], 20'h00000);
    check("t1_ci2", coeff_i[59:40], 20'h40000);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_coeff_i", coeff_i, init_v);

    // y0=(0,0.5): conj flips the imaginary sign
    yy_i = '0;
    yy_q[19:0] = 20'h40000;
    pulse();
    wait_done(lat);
    check("t2_ci0", coeff_i[19:0], 20'h00000);
    check("t2_cq0", coeff_q[19:0], 20'hF0000);

    // Saturation: near-full-scale everywhere, 8 passes
    yy_i = sat_v;
    yy_q = sat_v;
    err_i = 20'h7FFFF;
    err_q = 20'h7FFFF;
    for (int p = 0; p < 8; p++) begin
      pulse();
      wait_done(lat);
    end
    check("sat_coeff_i", coeff_i, sat_v);

    // clr at T0+8 aborts the pass
    upd0 = n_upd;
    pulse();
    repeat (7) @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("abort_coeff_i", coeff_i, init_v);
    check("abort_busy", busy, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    @(negedge clk);
    check("abort_no_done", dcnt, 0);
    check("abort_n_upd", n_upd, upd0);

    // Continuous strobes for 40 cycles
    yy_i = '0;
    yy_q = '0;
    yy_i[79:60] = 20'h01234;
    yy_q[79:60] = 20'hFF800;
    err_i = 20'h03000;
    err_q = 20'h00100;
    mu_shift = 4'd3;
    upd0 = n_upd;
    drop0 = n_drop;
    dcnt = 0;
    smp_vld = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    @(negedge clk);
    smp_vld = 1'b0;
    check("burst_drops", n_drop - drop0, 16'd37);
    check("burst_dones", dcnt, 2);
    repeat (20) @(negedge clk);
    check("burst_upd", n_upd - upd0, 16'd3);

    // Strobe with en low is dropped
    en = 1'b0;
    drop0 = n_drop;
    pulse();
    check("en0_drop", n_drop - drop0, 16'd1);
    check("en0_busy", busy, 1'b0);
    en = 1'b1;

    // Tiny step: negative product floors to -1 LSB; en falls mid-pass
    yy_i = '0;
    yy_q = '0;
    yy_i[119:100] = 20'h00100;
    err_i = 20'hFFF00;
    err_q = 20'h00000;
    mu_shift = 4'd15;
    pulse();
    en = 1'b0;
    wait_done(lat);
    en = 1'b1;
    check("tiny_latency", lat, 17);
    check("tiny_ci5", coeff_i[119:100], 20'hFFFFF);
    check("tiny_cq5", coeff_q[119:100], 20'h00000);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
